// File: rtl/rice_core_wb_stage.sv
// Write-back stage: owns the integer register file (with write-through bypass to ID)
// and the cycle/instret counters with CSR write access.
module rice_core_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_enable,
  input  logic            i_ex_valid,
  input  logic [4:0]      i_ex_rd,
  input  logic [XLEN-1:0] i_ex_rd_value,
  input  logic            i_stall,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  output logic [XLEN-1:0] o_rs1_value,
  output logic [XLEN-1:0] o_rs2_value,
  output logic            o_retire,
  input  logic            i_cycle_inhibit,
  input  logic            i_instret_inhibit,
  input  logic            i_counter_write,
  input  logic [1:0]      i_counter_select,
  input  logic [XLEN-1:0] i_counter_write_data,
  output logic [63:0]     o_cycle,
  output logic [63:0]     o_instret
);

  logic            retire;
  logic [XLEN-1:0] regs_reg [1:31];
  logic [63:0]     cycle_reg, cycle_next;
  logic [63:0]     instret_reg, instret_next;
  logic [63:0]     counter_wdata;
  logic            counter_wr;
  logic [4:0]      rd_idx [2];

  // Gating with reset keeps the bypass path and the retire pulse dead while reset is held.
  assign retire   = !i_rst && i_enable && i_ex_valid && !i_stall;
  assign o_retire = retire;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 1; i < 32; i++) regs_reg[i] <= '0;
    end else if (retire && i_ex_rd != 5'd0) begin
      regs_reg[i_ex_rd] <= i_ex_rd_value;
    end
  end

  assign rd_idx[0] = i_rs1;
  assign rd_idx[1] = i_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [XLEN-1:0] value;
      always_comb begin
        value = '0;
        if (rd_idx[gi] == 5'd0)
          value = '0;
        else if (retire && rd_idx[gi] == i_ex_rd)
          value = i_ex_rd_value;
        else
          value = regs_reg[rd_idx[gi]];
      end
    end
  endgenerate

  assign o_rs1_value = g_rd[0].value;
  assign o_rs2_value = g_rd[1].value;

  generate
    if (XLEN == 64) begin : g_wdata64
      assign counter_wdata = i_counter_write_data;
    end else begin : g_wdata32
      assign counter_wdata = {32'd0, i_counter_write_data};
    end
  endgenerate

  assign counter_wr = i_counter_write && i_enable;

  // A CSR write to one counter replaces its increment; the other counter is unaffected.
  always_comb begin
    cycle_next   = cycle_reg;
    instret_next = instret_reg;
    if (i_enable && !i_cycle_inhibit)
      cycle_next = cycle_reg + 64'd1;
    if (retire && !i_instret_inhibit)
      instret_next = instret_reg + 64'd1;
    if (counter_wr) begin
      case (i_counter_select)
        2'b00: begin
          if (XLEN == 64) cycle_next = counter_wdata;
          else            cycle_next = {cycle_reg[63:32], counter_wdata[31:0]};
        end
        2'b01: begin
          if (XLEN == 32) cycle_next = {counter_wdata[31:0], cycle_reg[31:0]};
        end
        2'b10: begin
          if (XLEN == 64) instret_next = counter_wdata;
          else            instret_next = {instret_reg[63:32], counter_wdata[31:0]};
        end
        default: begin
          if (XLEN == 32) instret_next = {counter_wdata[31:0], instret_reg[31:0]};
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cycle_reg   <= '0;
      instret_reg <= '0;
    end else begin
      cycle_reg   <= cycle_next;
      instret_reg <= instret_next;
    end
  end

  assign o_cycle   = cycle_reg;
  assign o_instret = instret_reg;

endmodule

// File: tb/tb_rice_core_wb_stage.sv
// Self-checking bench for rice_core_wb_stage (XLEN=32): vector table, directed
// counter/stall/reset sequences, and randomized traffic against a reference model.
module tb_rice_core_wb_stage;

  logic        clk;
  logic        rst;
  logic        en, valid, stall;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] val;
  logic [31:0] rs1_value, rs2_value;
  logic        retire;
  logic        cinh, iinh, cw;
  logic [1:0]  sel;
  logic [31:0] wd;
  logic [63:0] cycle, instret;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_regs [32];
  logic [63:0] m_cycle, m_instret;

  rice_core_wb_stage #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_ex_valid(valid),
    .i_ex_rd(rd), .i_ex_rd_value(val), .i_stall(stall),
    .i_rs1(rs1), .i_rs2(rs2), .o_rs1_value(rs1_value), .o_rs2_value(rs2_value),
    .o_retire(retire), .i_cycle_inhibit(cinh), .i_instret_inhibit(iinh),
    .i_counter_write(cw), .i_counter_select(sel), .i_counter_write_data(wd),
    .o_cycle(cycle), .o_instret(instret)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        en, valid, stall;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] val;
    logic        exp_ret;
    logic [31:0] exp_rs1, exp_rs2;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic ret);
    if (idx == 5'd0) return 32'd0;
    if (ret && idx == rd) return val;
    return m_regs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cycle   = 64'd0;
    m_instret = 64'd0;
  endtask

  task automatic idle_inputs();
    en = 1; valid = 0; stall = 0; rd = 0; val = 0; rs1 = 0; rs2 = 0;
    cinh = 0; iinh = 0; cw = 0; sel = 0; wd = 0;
  endtask

  // Inputs are already driven; check combinational outputs, take one edge, check counters.
  task automatic run_cycle();
    logic        ret;
    logic [63:0] nc, ni, t;
    #1;
    ret = en && valid && !stall;
    check("retire", {63'd0, retire}, {63'd0, ret});
    check("rs1_value", {32'd0, rs1_value}, {32'd0, model_read(rs1, ret)});
    check("rs2_value", {32'd0, rs2_value}, {32'd0, model_read(rs2, ret)});
    nc = m_cycle + ((en && !cinh) ? 64'd1 : 64'd0);
    ni = m_instret + ((ret && !iinh) ? 64'd1 : 64'd0);
    if (cw && en) begin
      t = sel[1] ? m_instret : m_cycle;
      if (sel[0]) t[63:32] = wd;
      else        t[31:0]  = wd;
      if (sel[1]) ni = t;
      else        nc = t;
    end
    @(posedge clk);
    #1;
    if (ret && rd != 5'd0) m_regs[rd] = val;
    m_cycle   = nc;
    m_instret = ni;
    check("cycle", cycle, m_cycle);
    check("instret", instret, m_instret);
  endtask

  initial begin
    logic [63:0] base_cycle, base_instret;

    tbl[0] = '{1, 1, 0, 5'd5, 5'd5, 5'd0, 32'h1234_5678, 1, 32'h1234_5678, 32'h0};
    tbl[1] = '{1, 0, 0, 5'd0, 5'd5, 5'd5, 32'h0,         0, 32'h1234_5678, 32'h1234_5678};
    tbl[2] = '{1, 1, 0, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF, 1, 32'h0,         32'h1234_5678};
    tbl[3] = '{1, 1, 1, 5'd7, 5'd7, 5'd5, 32'h55,        0, 32'h0,         32'h1234_5678};
    tbl[4] = '{0, 1, 0, 5'd7, 5'd7, 5'd5, 32'h55,        0, 32'h0,         32'h1234_5678};
    tbl[5] = '{1, 1, 0, 5'd7, 5'd7, 5'd7, 32'h55,        1, 32'h55,        32'h55};
    tbl[6] = '{1, 0, 0, 5'd0, 5'd7, 5'd5, 32'h0,         0, 32'h55,        32'h1234_5678};
    tbl[7] = '{1, 1, 0, 5'd5, 5'd5, 5'd7, 32'hAAAA,      1, 32'hAAAA,      32'h55};
    tbl[8] = '{1, 0, 0, 5'd0, 5'd5, 5'd0, 32'h0,         0, 32'hAAAA,      32'h0};

    // Reset held across edges with a would-be retire on the inputs.
    idle_inputs();
    rst = 1; valid = 1; rd = 5'd3; val = 32'h5; rs1 = 5'd3; rs2 = 5'd3;
    #12;
    check("reset_retire", {63'd0, retire}, 64'd0);
    check("reset_rs1", {32'd0, rs1_value}, 64'd0);
    check("reset_rs2", {32'd0, rs2_value}, 64'd0);
    check("reset_cycle", cycle, 64'd0);
    check("reset_instret", instret, 64'd0);
    en = 0; valid = 0;
    #5 rst = 0;
    model_reset();
    @(posedge clk); #1;
    check("idle_cycle", cycle, 64'd0);

    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      en = tbl[i].en; valid = tbl[i].valid; stall = tbl[i].stall; rd = tbl[i].rd;
      val = tbl[i].val; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
      #1;
      check("tbl_retire", {63'd0, retire}, {63'd0, tbl[i].exp_ret});
      check("tbl_rs1", {32'd0, rs1_value}, {32'd0, tbl[i].exp_rs1});
      check("tbl_rs2", {32'd0, rs2_value}, {32'd0, tbl[i].exp_rs2});
      $display("[TB] vec %0d en=%0d v=%0d st=%0d rd=%0d val=%h rs1=%h rs2=%h ret=%0d",
               i, en, valid, stall, rd, val, rs1_value, rs2_value, retire);
      run_cycle();
    end
    check("tbl_cycle_total", cycle, 64'd8);
    check("tbl_instret_total", instret, 64'd4);

    // EX result held under stall for 3 cycles retires exactly once.
    base_instret = m_instret;
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      valid = 1; rd = 5'd9; val = 32'h99; rs1 = 5'd9; stall = (i < 3);
      run_cycle();
    end
    idle_inputs(); rs1 = 5'd9;
    run_cycle();
    check("stall_instret", instret, base_instret + 64'd1);
    $display("[TB] stall seq x9 retired once, instret=%0d", instret);

    // Carry from bit 31 into 32, then high-half write with low half holding.
    idle_inputs(); cw = 1; sel = 2'b00; wd = 32'hFFFF_FFFF;
    run_cycle();
    check("cyc_lo_write", cycle, 64'h0000_0000_FFFF_FFFF);
    idle_inputs();
    run_cycle();
    check("cyc_carry", cycle, 64'h0000_0001_0000_0000);
    run_cycle();
    idle_inputs(); cw = 1; sel = 2'b01; wd = 32'hA;
    run_cycle();
    check("cyc_hi_write", cycle, 64'h0000_000A_0000_0001);
    $display("[TB] cycle counter write/carry seq cycle=%h", cycle);

    // instret inhibited over 4 retires; cycle still counts.
    base_cycle = m_cycle; base_instret = m_instret;
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); iinh = 1; valid = 1; rd = 5'(10 + i); val = 32'h100 + 32'(i);
      run_cycle();
    end
    idle_inputs(); rs1 = 5'd13; rs2 = 5'd10; #1;
    check("inh_x13", {32'd0, rs1_value}, 64'h103);
    check("inh_x10", {32'd0, rs2_value}, 64'h100);
    check("inh_instret", instret, base_instret);
    check("inh_cycle", cycle, base_cycle + 64'd4);
    $display("[TB] instret inhibit seq instret=%0d cycle=%0d", instret, cycle);

    // instret wraps from all-ones to zero.
    idle_inputs(); cw = 1; sel = 2'b10; wd = 32'hFFFF_FFFF; run_cycle();
    idle_inputs(); cw = 1; sel = 2'b11; wd = 32'hFFFF_FFFF; run_cycle();
    check("ins_all_ones", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    idle_inputs(); valid = 1; rd = 5'd1; val = 32'h1; run_cycle();
    check("ins_wrap", instret, 64'd0);
    $display("[TB] instret wrap seq instret=%h", instret);

    // Asynchronous reset mid-stall clears everything without an edge.
    idle_inputs(); stall = 1; valid = 1; rd = 5'd7; val = 32'h77; rs1 = 5'd7; rs2 = 5'd5;
    #1;
    check("pre_rst_x7", {32'd0, rs1_value}, 64'h55);
    rst = 1;
    #1;
    check("arst_rs1", {32'd0, rs1_value}, 64'd0);
    check("arst_rs2", {32'd0, rs2_value}, 64'd0);
    check("arst_cycle", cycle, 64'd0);
    check("arst_instret", instret, 64'd0);
    stall = 0; #1;
    check("arst_retire", {63'd0, retire}, 64'd0);
    @(posedge clk); #3;
    idle_inputs(); rst = 0;
    model_reset();
    @(posedge clk); #1;
    check("post_rst_cycle", cycle, 64'd1);
    m_cycle = 64'd1;
    rs1 = 5'd7; #1;
    check("post_rst_x7", {32'd0, rs1_value}, 64'd0);
    $display("[TB] async reset seq done cycle=%0d", cycle);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      en = ($urandom_range(0, 7) != 0);
      valid = $urandom_range(0, 1);
      stall = ($urandom_range(0, 3) == 0);
      rd = 5'($urandom_range(0, 31));
      val = $urandom;
      rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      cinh = ($urandom_range(0, 7) == 0);
      iinh = ($urandom_range(0, 7) == 0);
      cw = ($urandom_range(0, 15) == 0);
      sel = 2'($urandom_range(0, 3));
      wd = $urandom;
      run_cycle();
      $display("[TB] rnd %0d en=%0d v=%0d st=%0d rd=%0d cw=%0d sel=%0d cyc=%h ins=%h",
               n, en, valid, stall, rd, cw, sel, cycle, instret);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
